// File: rtl/mp_sequencer_if.sv
// rtl/mp_sequencer_if.sv - fetch handshake and datapath strobe bundle for mp_sequencer
interface mp_sequencer_if;
   logic       instr_req;
   logic       instr_valid;
   logic [1:0] instr_op;
   logic       ir_load;
   logic       pc_write;
   logic       pc_branch;
   logic       reg_write;
   logic       mem_to_reg;
   logic       mem_read;
   logic       mem_write;

   modport master (
      output instr_req, ir_load, pc_write, pc_branch,
             reg_write, mem_to_reg, mem_read, mem_write,
      input  instr_valid, instr_op
   );

   modport slave (
      input  instr_req, ir_load, pc_write, pc_branch,
             reg_write, mem_to_reg, mem_read, mem_write,
      output instr_valid, instr_op
   );
endinterface

// File: rtl/mp_sequencer.sv
// rtl/mp_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the 8-bit datapath
// Optional performance counters enabled by defining SEQ_PERF_CNT_EN.
module mp_sequencer #(
   parameter int FETCH_TIMEOUT = 15,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             step,
   mp_sequencer_if.master   bus,
   output logic             busy,
   output logic             fault,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_FAULT  = 3'd7
   } state_t;

   localparam logic [1:0] OP_LW  = 2'd0;
   localparam logic [1:0] OP_SW  = 2'd1;
   localparam logic [1:0] OP_ADD = 2'd2;
   localparam logic [1:0] OP_BR  = 2'd3;

   localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t     st;
   logic [1:0] op_q;
   logic       step_q;
   logic [7:0] wait_cnt;
   logic       fault_q;
   logic       step_rise;
   logic       retire;

   assign step_rise = step && !step_q;

   // Final cycle of each instruction; gated by reset so an aborted one never counts.
   assign retire = !reset && ((st == S_EXEC && op_q == OP_BR) ||
                              (st == S_MEM  && op_q == OP_SW) ||
                              (st == S_WB));

   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= S_IDLE;
         op_q     <= OP_LW;
         step_q   <= 1'b0;
         wait_cnt <= 8'd0;
         fault_q  <= 1'b0;
      end else begin
         step_q <= step;
         unique case (st)
            S_IDLE: begin
               if (run || step_rise)
                  st <= S_FETCH;
            end
            S_FETCH: begin
               if (bus.instr_valid) begin
                  op_q     <= bus.instr_op;
                  wait_cnt <= 8'd0;
                  st       <= S_DECODE;
               end else if (wait_cnt == WAIT_LAST) begin
                  st      <= S_FAULT;
                  fault_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_DECODE: st <= S_EXEC;
            S_EXEC: begin
               if (retire)
                  st <= run ? S_FETCH : S_IDLE;
               else if (op_q == OP_ADD)
                  st <= S_WB;
               else
                  st <= S_MEM;
            end
            S_MEM: begin
               if (retire)
                  st <= run ? S_FETCH : S_IDLE;
               else
                  st <= S_WB;
            end
            S_WB:    st <= run ? S_FETCH : S_IDLE;
            S_FAULT: st <= S_FAULT;
            default: st <= S_IDLE;
         endcase
      end
   end

   // Strobes decode from the current state; the reset cycle forces them low mid-instruction.
   always_comb begin
      bus.instr_req  = 1'b0;
      bus.ir_load    = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_branch  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      if (!reset) begin
         unique case (st)
            S_FETCH: begin
               bus.instr_req = 1'b1;
               bus.ir_load   = bus.instr_valid;
            end
            S_EXEC: begin
               if (op_q == OP_BR) begin
                  bus.pc_write  = 1'b1;
                  bus.pc_branch = 1'b1;
               end
            end
            S_MEM: begin
               if (op_q == OP_SW) begin
                  bus.mem_write = 1'b1;
                  bus.pc_write  = 1'b1;
               end else begin
                  bus.mem_read  = 1'b1;
               end
            end
            S_WB: begin
               bus.reg_write  = 1'b1;
               bus.pc_write   = 1'b1;
               bus.mem_to_reg = (op_q == OP_LW);
            end
            default: ;
         endcase
      end
   end

   assign busy  = (st != S_IDLE) && (st != S_FAULT);
   assign fault = fault_q;
   assign state = st;

`ifdef SEQ_PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cyc_q;
   logic [CNT_W-1:0] ins_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         if (busy && !(&cyc_q))
            cyc_q <= cyc_q + CNT_ONE;
         if (retire && !(&ins_q))
            ins_q <= ins_q + CNT_ONE;
      end
   end

   assign cycle_cnt = cyc_q;
   assign instr_cnt = ins_q;
`else
   assign cycle_cnt = '0;
   assign instr_cnt = '0;
`endif

endmodule
